// File: rtl/usb_dfu_flash_sequencer_pkg.sv
// usb_dfu_flash_sequencer_pkg: DFU status codes, sequencer states and image-region defaults.
package usb_dfu_flash_sequencer_pkg;
    localparam int          DEF_PAGE_SIZE   = 256;
    localparam logic [15:0] DEF_BASE_PAGE   = 16'h0280;
    localparam logic [15:0] DEF_IMAGE_PAGES = 16'h0580;
    localparam logic [23:0] DEF_TIMEOUT     = 24'hFFFFFF;

    typedef enum logic [3:0] {
        ST_OK          = 4'h0,
        ST_ERR_WRITE   = 4'h3,
        ST_ERR_ADDRESS = 4'h8,
        ST_ERR_UNKNOWN = 4'hE
    } dfu_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_XFER,
        S_WR_WAIT,
        S_RD_XFER,
        S_DRAIN,
        S_DONE
    } seq_state_e;
endpackage

// File: rtl/usb_dfu_timeout.sv
// usb_dfu_timeout: loadable 24-bit down-counter; o_expire pulses on the last enabled cycle.
module usb_dfu_timeout
    import usb_dfu_flash_sequencer_pkg::*;
#(
    parameter logic [23:0] LOAD = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    logic [23:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)                   r_cnt <= '0;
        else if (i_load)                r_cnt <= LOAD;
        else if (i_en && r_cnt != 24'd0) r_cnt <= r_cnt - 24'd1;
    end

    assign o_expire = i_en && !i_load && r_cnt == 24'd1;
endmodule

// File: rtl/usb_dfu_flash_sequencer.sv
// usb_dfu_flash_sequencer: turns DFU DNLOAD/UPLOAD blocks into usb_spiflash_bridge page operations
// and reports busy/done/bStatus for GETSTATUS.
module usb_dfu_flash_sequencer
    import usb_dfu_flash_sequencer_pkg::*;
#(
    parameter int          PAGE_SIZE   = DEF_PAGE_SIZE,
    parameter logic [15:0] BASE_PAGE   = DEF_BASE_PAGE,
    parameter logic [15:0] IMAGE_PAGES = DEF_IMAGE_PAGES,
    parameter logic [23:0] TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dn_start,
    input  logic        i_up_start,
    input  logic [15:0] i_blk_num,
    input  logic [8:0]  i_blk_len,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_manifest,
    output logic [3:0]  o_status,
    output logic [15:0] o_flash_address,
    output logic        o_flash_rd_request,
    output logic        o_flash_wr_request,
    input  logic        i_flash_wr_busy,
    input  logic        i_flash_wr_get,
    input  logic        i_flash_rd_put
);
    seq_state_e  r_state, w_next;
    dfu_status_e r_status, w_status;
    logic [15:0] r_addr;
    logic [8:0]  r_len, r_cnt, w_cnt_nxt;
    logic        r_seen_busy, r_manifest;
    logic        w_accept, w_tick, w_last, w_expire, w_tmr_en;

    assign w_tick    = (r_state == S_WR_XFER && i_flash_wr_get) || (r_state == S_RD_XFER && i_flash_rd_put);
    assign w_cnt_nxt = r_cnt + {8'd0, w_tick};
    assign w_last    = w_cnt_nxt == r_len;
    assign w_tmr_en  = r_state inside {S_WR_XFER, S_WR_WAIT, S_RD_XFER};

    usb_dfu_timeout #(.LOAD(TIMEOUT)) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_accept),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next   = r_state;
        w_status = r_status;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: if (i_dn_start || i_up_start) begin
                w_accept = 1'b1;
                w_status = (i_blk_num >= IMAGE_PAGES) ? ST_ERR_ADDRESS : ST_OK;
                w_next   = (i_blk_num >= IMAGE_PAGES || i_blk_len == 9'd0) ? S_DONE :
                           i_dn_start ? S_WR_XFER : S_RD_XFER;
            end
            S_WR_XFER: begin
                w_next   = w_last ? S_WR_WAIT : (i_abort || w_expire) ? S_DRAIN : S_WR_XFER;
                w_status = (!w_last && !i_abort && w_expire) ? ST_ERR_WRITE : r_status;
            end
            // bridge busy lags the request by a cycle, so only a seen-then-cleared busy means programmed
            S_WR_WAIT: begin
                w_next   = (r_seen_busy && !i_flash_wr_busy) ? S_DONE : w_expire ? S_DRAIN : S_WR_WAIT;
                w_status = (!(r_seen_busy && !i_flash_wr_busy) && w_expire) ? ST_ERR_WRITE : r_status;
            end
            S_RD_XFER: begin
                w_next   = (w_last || i_abort || w_expire) ? S_DONE : S_RD_XFER;
                w_status = (!w_last && !i_abort && w_expire) ? ST_ERR_UNKNOWN : r_status;
            end
            S_DRAIN: w_next = i_flash_wr_busy ? S_DRAIN : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_status    <= ST_OK;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_manifest  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_status <= w_status;
            r_cnt    <= w_accept ? 9'd0 : w_cnt_nxt;
            if (w_accept) begin
                r_addr      <= BASE_PAGE + i_blk_num;
                r_len       <= (i_blk_len > 9'(PAGE_SIZE)) ? 9'(PAGE_SIZE) : i_blk_len;
                r_seen_busy <= 1'b0;
                r_manifest  <= i_dn_start && i_blk_len == 9'd0 && i_blk_num < IMAGE_PAGES;
            end else if (r_state == S_WR_WAIT && i_flash_wr_busy) begin
                r_seen_busy <= 1'b1;
            end
        end
    end

    assign o_busy             = r_state inside {S_WR_XFER, S_WR_WAIT, S_RD_XFER, S_DRAIN};
    assign o_done             = r_state == S_DONE;
    assign o_manifest         = r_state == S_DONE && r_manifest;
    assign o_status           = r_status;
    assign o_flash_address    = r_addr;
    assign o_flash_wr_request = r_state == S_WR_XFER;
    assign o_flash_rd_request = r_state == S_RD_XFER;
endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
// tb_usb_dfu_flash_sequencer: directed DNLOAD/UPLOAD/abort/timeout/reset scenarios against a bridge model,
// with per-operation expectations queued at start and checked when done pulses.
module tb_usb_dfu_flash_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dn = 1'b0, up = 1'b0, abort = 1'b0;
    logic [15:0] blk = '0;
    logic [8:0]  len = '0;
    logic        wr_busy = 1'b0, wr_get = 1'b0, rd_put = 1'b0;
    logic        busy, done, manifest, rd_req, wr_req;
    logic [3:0]  status;
    logic [15:0] addr;

    always #5 clk = ~clk;

    usb_dfu_flash_sequencer #(.TIMEOUT(24'd1000)) dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .i_dn_start         (dn),
        .i_up_start         (up),
        .i_blk_num          (blk),
        .i_blk_len          (len),
        .i_abort            (abort),
        .o_busy             (busy),
        .o_done             (done),
        .o_manifest         (manifest),
        .o_status           (status),
        .o_flash_address    (addr),
        .o_flash_rd_request (rd_req),
        .o_flash_wr_request (wr_req),
        .i_flash_wr_busy    (wr_busy),
        .i_flash_wr_get     (wr_get),
        .i_flash_rd_put     (rd_put)
    );

    typedef struct {
        logic [3:0]  st;
        logic        man;
        int          wr_n;
        int          rd_n;
        logic        req;
        logic [15:0] addr;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, done_cnt = 0;
    int   gets = 0, puts = 0;
    logic any_req = 1'b0, both_hi = 1'b0;
    int   busy_len = 40, bcnt = 0;
    bit   stuck = 1'b0, early = 1'b0, pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bridge model: one byte per cycle while requested, then busy_len cycles of program time
    always @(negedge clk) begin
        wr_get = wr_req;
        rd_put = rd_req;
        if (wr_req) pending = 1'b1;
        else if (pending) begin
            pending = 1'b0;
            bcnt    = busy_len;
        end
        wr_busy = stuck || (early && wr_req) || bcnt > 0;
        if (bcnt > 0) bcnt--;
    end

    always @(posedge clk) begin
        if ((dn || up) && !busy) begin
            gets = 0; puts = 0; any_req = 1'b0; both_hi = 1'b0;
        end else begin
            if (wr_get) gets++;
            if (rd_put) puts++;
            if (wr_req || rd_req) any_req = 1'b1;
            if (wr_req && rd_req) both_hi = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            chk("sb_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("status", 32'(status), 32'(e.st));
                chk("manifest", 32'(manifest), 32'(e.man));
                chk("address", 32'(addr), 32'(e.addr));
                chk("any_request", 32'(any_req), 32'(e.req));
                chk("req_exclusive", 32'(both_hi), 32'd0);
                if (e.wr_n >= 0) chk("wr_bytes", 32'(gets), 32'(e.wr_n));
                if (e.rd_n >= 0) chk("rd_bytes", 32'(puts), 32'(e.rd_n));
            end
        end
    end

    task automatic start(input bit d, input bit u, input logic [15:0] b, input logic [8:0] l,
                         input logic [3:0] st, input bit man, input int wn, input int rn, input bit rq);
        exp_t e;
        e.st = st; e.man = man; e.wr_n = wn; e.rd_n = rn; e.req = rq; e.addr = 16'h0280 + b;
        q.push_back(e);
        dn = d; up = u; blk = b; len = l;
        @(negedge clk);
        dn = 1'b0; up = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin
        int d0, n;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_manifest", 32'(manifest), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        d0 = done_cnt;
        start(1, 0, 16'd0, 9'd256, 4'h0, 0, 256, 0, 1);
        chk("wr_req_after_start", 32'(wr_req), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(d0, 600, "write256");
        repeat (3) @(negedge clk);

        d0 = done_cnt;
        start(1, 0, 16'h0580, 9'd256, 4'h8, 0, 0, 0, 0);
        wait_done(d0, 2, "out_of_range");
        repeat (2) @(negedge clk);

        d0 = done_cnt;
        start(1, 0, 16'd5, 9'd0, 4'h0, 1, 0, 0, 0);
        wait_done(d0, 2, "manifest");
        repeat (2) @(negedge clk);

        d0 = done_cnt;
        start(0, 1, 16'd3, 9'd64, 4'h0, 0, 0, 64, 1);
        chk("rd_req_after_start", 32'(rd_req), 32'd1);
        chk("rd_addr", 32'(addr), 32'h0283);
        repeat (10) @(negedge clk);
        dn = 1'b1; blk = 16'd7; len = 9'd16;
        @(negedge clk);
        dn = 1'b0;
        chk("start_ignored_addr", 32'(addr), 32'h0283);
        chk("start_ignored_wr", 32'(wr_req), 32'd0);
        wait_done(d0, 200, "upload64");
        repeat (2) @(negedge clk);

        d0 = done_cnt;
        start(1, 1, 16'd1, 9'd16, 4'h0, 0, 16, 0, 1);
        wait_done(d0, 100, "dn_wins");
        repeat (2) @(negedge clk);

        early = 1'b1;
        d0 = done_cnt;
        start(1, 0, 16'd2, 9'd256, 4'h0, 0, -1, 0, 1);
        n = 0;
        while (gets < 100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_100", 32'(gets >= 100), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_req_dropped", 32'(wr_req), 32'd0);
        chk("abort_busy_held", 32'(busy), 32'd1);
        chk("abort_not_done", 32'(done_cnt == d0), 32'd1);
        wait_done(d0, 100, "abort");
        early = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ignored", 32'(busy), 32'd0);

        stuck = 1'b1;
        d0 = done_cnt;
        start(1, 0, 16'd1, 9'd256, 4'h3, 0, 256, 0, 1);
        repeat (1100) @(negedge clk);
        chk("timeout_no_done", 32'(done_cnt == d0), 32'd1);
        chk("timeout_drain_busy", 32'(busy), 32'd1);
        chk("timeout_status", 32'(status), 32'h3);
        stuck = 1'b0;
        wait_done(d0, 5, "timeout");
        repeat (50) @(negedge clk);

        start(1, 0, 16'd4, 9'd256, 4'h0, 0, 256, 0, 1);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_wr_req", 32'(wr_req), 32'd0);
        chk("async_rst_addr", 32'(addr), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        start(0, 1, 16'd0, 9'd8, 4'h0, 0, 0, 8, 1);
        wait_done(d0, 50, "post_reset_upload");
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
